// File: rtl/xgmii_frame_tx_64.sv
// Frames AXI-Stream beats onto 64-bit XGMII: start/preamble, optional padding, terminate, IFG, error words.
// One cycle from an accepted beat (or from tvalid in IDLE) to the registered XGMII word.
module xgmii_frame_tx_64 #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int IFG_BYTES       = 12,
    parameter int ENABLE_PADDING  = 1,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] xgmii_txd,
    output logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic                  tx_start_packet,
    output logic                  tx_underflow,
    output logic                  tx_bad_frame
);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_TERM, S_IFG, S_DISCARD} state_t;

    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;
    localparam logic [63:0] ERR_WORD   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [15:0] MIN_BYTES  = 16'(MIN_FRAME_BYTES);
    localparam int          IFG_GAP0   = IFG_BYTES - 7;
    localparam logic [7:0]  IFG_W0     = (IFG_GAP0 > 0) ? 8'((IFG_GAP0 + 7) / 8) : 8'd0;

    // Idle words still owed after a terminate in lane t (lanes above t already count as idle).
    function automatic logic [7:0] ifg_words(input logic [3:0] lane);
        int gap;
        gap = IFG_BYTES - (7 - int'(lane));
        if (gap <= 0) return 8'd0;
        return 8'((gap + 7) / 8);
    endfunction

    function automatic logic [71:0] term_at(input logic [63:0] d, input logic [3:0] lane);
        logic [63:0] w;
        logic [7:0]  c;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(lane)) begin
                w[8*i +: 8] = d[8*i +: 8];
                c[i]        = 1'b0;
            end else if (i == int'(lane)) begin
                w[8*i +: 8] = 8'hFD;
                c[i]        = 1'b1;
            end else begin
                w[8*i +: 8] = 8'h07;
                c[i]        = 1'b1;
            end
        end
        return {c, w};
    endfunction

    function automatic logic [63:0] keep_mask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        return w;
    endfunction

    state_t      state, state_nxt;
    logic [15:0] byte_cnt, byte_cnt_nxt;
    logic [7:0]  ifg_rem, ifg_rem_nxt;
    logic [3:0]  disc_cnt, disc_cnt_nxt;
    logic [63:0] txd_nxt;
    logic [7:0]  txc_nxt;
    logic        start_nxt, unf_nxt, bad_nxt;

    logic        accept;
    logic [3:0]  n_bytes;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_add;
    logic        pad_need;
    logic [15:0] gap_left;
    logic [63:0] beat_dat;
    logic [3:0]  term_lane;
    logic [7:0]  ifg_w;

    assign s_axis_tready = (state == S_DATA) || (state == S_DISCARD);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign n_bytes       = 4'($countones(s_axis_tkeep));
    assign cnt_sum       = {1'b0, byte_cnt} + {13'd0, n_bytes};
    assign cnt_add       = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign pad_need      = (ENABLE_PADDING != 0) && (cnt_add < MIN_BYTES);
    // Every beat before tlast is full, so byte_cnt is a multiple of 8 here and gap_left < 8 is the lane.
    assign gap_left      = MIN_BYTES - byte_cnt;
    assign beat_dat      = keep_mask(s_axis_tdata, s_axis_tkeep);
    assign term_lane     = ((state == S_PAD) || pad_need) ? gap_left[3:0] : n_bytes;
    assign ifg_w         = ifg_words(term_lane);

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state           <= S_IDLE;
            byte_cnt        <= '0;
            ifg_rem         <= '0;
            disc_cnt        <= '0;
            xgmii_txd       <= IDLE_WORD;
            xgmii_txc       <= 8'hFF;
            tx_start_packet <= 1'b0;
            tx_underflow    <= 1'b0;
            tx_bad_frame    <= 1'b0;
        end else begin
            state           <= state_nxt;
            byte_cnt        <= byte_cnt_nxt;
            ifg_rem         <= ifg_rem_nxt;
            disc_cnt        <= disc_cnt_nxt;
            xgmii_txd       <= txd_nxt;
            xgmii_txc       <= txc_nxt;
            tx_start_packet <= start_nxt;
            tx_underflow    <= unf_nxt;
            tx_bad_frame    <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        ifg_rem_nxt  = ifg_rem;
        disc_cnt_nxt = disc_cnt;
        case (state)
            S_IDLE: if (s_axis_tvalid) begin
                state_nxt    = S_DATA;
                byte_cnt_nxt = '0;
            end
            S_DATA: if (!s_axis_tvalid) begin
                state_nxt    = S_DISCARD;
                disc_cnt_nxt = '0;
            end else begin
                byte_cnt_nxt = cnt_add;
                if (s_axis_tlast) begin
                    if (s_axis_tuser) begin
                        state_nxt = S_TERM;
                    end else if ((pad_need && gap_left < 16'd8) || (!pad_need && n_bytes != 4'd8)) begin
                        state_nxt   = (ifg_w == 8'd0) ? S_IDLE : S_IFG;
                        ifg_rem_nxt = ifg_w;
                    end else if (pad_need && gap_left == 16'd8) begin
                        state_nxt = S_TERM;
                    end else if (pad_need) begin
                        state_nxt    = S_PAD;
                        byte_cnt_nxt = byte_cnt + 16'd8;
                    end else begin
                        state_nxt = S_TERM;
                    end
                end
            end
            S_PAD: begin
                byte_cnt_nxt = byte_cnt + 16'd8;
                if (gap_left == 16'd8) begin
                    state_nxt = S_TERM;
                end else if (gap_left < 16'd8) begin
                    state_nxt   = (ifg_w == 8'd0) ? S_IDLE : S_IFG;
                    ifg_rem_nxt = ifg_w;
                end
            end
            S_TERM: begin
                state_nxt   = (IFG_W0 == 8'd0) ? S_IDLE : S_IFG;
                ifg_rem_nxt = IFG_W0;
            end
            S_IFG: begin
                if (ifg_rem <= 8'd1) state_nxt = S_IDLE;
                ifg_rem_nxt = ifg_rem - 8'd1;
            end
            S_DISCARD: begin
                if (disc_cnt != 4'hF) disc_cnt_nxt = disc_cnt + 4'd1;
                // disc_cnt equals the idle words emitted so far including this cycle's.
                if (accept && s_axis_tlast) begin
                    if (IFG_W0 > {4'd0, disc_cnt}) begin
                        state_nxt   = S_IFG;
                        ifg_rem_nxt = IFG_W0 - {4'd0, disc_cnt};
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        txd_nxt   = IDLE_WORD;
        txc_nxt   = 8'hFF;
        start_nxt = 1'b0;
        unf_nxt   = 1'b0;
        bad_nxt   = 1'b0;
        case (state)
            S_IDLE: if (s_axis_tvalid) begin
                txd_nxt   = START_WORD;
                txc_nxt   = 8'h01;
                start_nxt = 1'b1;
            end
            S_DATA: if (!s_axis_tvalid) begin
                txd_nxt = ERR_WORD;
                unf_nxt = 1'b1;
            end else if (s_axis_tlast && s_axis_tuser) begin
                txd_nxt = ERR_WORD;
                bad_nxt = 1'b1;
            end else if (s_axis_tlast && ((pad_need && gap_left < 16'd8) || (!pad_need && n_bytes != 4'd8))) begin
                {txc_nxt, txd_nxt} = term_at(beat_dat, term_lane);
            end else begin
                txd_nxt = beat_dat;
                txc_nxt = 8'h00;
            end
            S_PAD: if (gap_left < 16'd8) begin
                {txc_nxt, txd_nxt} = term_at(64'd0, term_lane);
            end else begin
                txd_nxt = 64'd0;
                txc_nxt = 8'h00;
            end
            S_TERM:    txd_nxt = TERM_WORD;
            S_DISCARD: if (disc_cnt == 4'd0) txd_nxt = TERM_WORD;
            default:   txd_nxt = IDLE_WORD;
        endcase
    end

endmodule

// File: tb/tb_xgmii_frame_tx_64.sv
// Directed-vector bench for xgmii_frame_tx_64: stimulus queues the expected word per clock, a monitor compares.
module tb_xgmii_frame_tx_64;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_start_packet;
    logic        tx_underflow;
    logic        tx_bad_frame;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM0_W = 64'h07070707070707FD;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] LAST_D  = 64'h8877665544332211;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        sp;
        logic        uf;
        logic        bf;
        logic        rdy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e, mon_got;
    string mon_nm;
    int    checks = 0;
    int    errors = 0;

    xgmii_frame_tx_64 dut (
        .tx_clk          (tx_clk),
        .tx_rst          (tx_rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .xgmii_txd       (xgmii_txd),
        .xgmii_txc       (xgmii_txc),
        .tx_start_packet (tx_start_packet),
        .tx_underflow    (tx_underflow),
        .tx_bad_frame    (tx_bad_frame)
    );

    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_got = {xgmii_txd, xgmii_txc, tx_start_packet, tx_underflow, tx_bad_frame, s_axis_tready};
            checks++;
            if (mon_got !== mon_e) begin
                errors++;
                $display("FAIL %s @%0t: got txd=%h txc=%h sp=%b uf=%b bf=%b rdy=%b, want txd=%h txc=%h sp=%b uf=%b bf=%b rdy=%b",
                         mon_nm, $time, mon_got.d, mon_got.c, mon_got.sp, mon_got.uf, mon_got.bf, mon_got.rdy,
                         mon_e.d, mon_e.c, mon_e.sp, mon_e.uf, mon_e.bf, mon_e.rdy);
            end
        end
    end

    function automatic logic [63:0] bd(input int f, input int b);
        logic [7:0] x;
        x = 8'(f * 16 + b);
        return 64'hF1E2D3C4B5A69788 ^ {8{x}};
    endfunction

    task automatic drv(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
    endtask

    // Queue the word expected at the coming edge (rdy is tready after that edge), then advance one clock.
    task automatic cyc(input string nm, input logic [63:0] d, input logic [7:0] c,
                       input logic sp, input logic uf, input logic bf, input logic rdy);
        exp_q.push_back(exp_t'({d, c, sp, uf, bf, rdy}));
        name_q.push_back(nm);
        @(posedge tx_clk);
        @(negedge tx_clk);
    endtask

    task automatic idle_w(input string nm);
        cyc(nm, IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_w();
        cyc("start", START_W, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_beats(input int f, input int cnt);
        for (int b = 0; b < cnt; b++) begin
            drv(1'b1, bd(f, b), 8'hFF, 1'b0, 1'b0);
            cyc("data", bd(f, b), 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic pad_13(input int f);
        send_beats(f, 1);
        drv(1'b1, LAST_D, 8'h1F, 1'b1, 1'b0);
        cyc("pad_first", 64'h0000005544332211, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
        repeat (5) cyc("pad_zero", 64'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tx_rst = 1'b1;
        drv(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
        repeat (3) idle_w("reset");
        tx_rst = 1'b0;
        idle_w("idle");

        // 64-byte frame, then a 13-byte frame waiting behind it
        drv(1'b1, bd(1, 0), 8'hFF, 1'b0, 1'b0);
        start_w();
        send_beats(1, 7);
        drv(1'b1, bd(1, 7), 8'hFF, 1'b1, 1'b0);
        cyc("data_last64", bd(1, 7), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, bd(2, 0), 8'hFF, 1'b0, 1'b0);
        cyc("term_lane0", TERM0_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_w("ifg_t0");
        start_w();

        // 13 bytes padded to 60
        pad_13(2);
        drv(1'b1, bd(3, 0), 8'hFF, 1'b0, 1'b0);
        cyc("pad_term_lane4", 64'h070707FD00000000, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_w("ifg_t4_a");
        idle_w("ifg_t4_b");
        start_w();

        // 58 bytes: padding terminates inside the tlast word
        send_beats(3, 7);
        drv(1'b1, LAST_D, 8'h03, 1'b1, 1'b0);
        cyc("pad_fit_term", 64'h070707FD00002211, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, bd(4, 0), 8'hFF, 1'b0, 1'b0);
        idle_w("ifg_fit_a");
        idle_w("ifg_fit_b");
        start_w();

        // back-to-back frames ending with tkeep 0x7F
        for (int f = 4; f <= 5; f++) begin
            send_beats(f, 8);
            drv(1'b1, LAST_D, 8'h7F, 1'b1, 1'b0);
            cyc("term_lane7", 64'hFD77665544332211, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
            drv(1'b1, bd(f + 1, 0), 8'hFF, 1'b0, 1'b0);
            idle_w("ifg_t7_a");
            idle_w("ifg_t7_b");
            start_w();
        end

        // underflow after beat 3 of a 10-beat frame
        send_beats(6, 3);
        drv(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
        cyc("underflow", ERR_W, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int b = 3; b <= 9; b++) begin
            drv(1'b1, bd(6, b), 8'hFF, b == 9, 1'b0);
            if (b == 3) cyc("discard_term", TERM0_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
            else        cyc("discard_idle", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0, b != 9);
        end
        drv(1'b1, bd(7, 0), 8'hFF, 1'b0, 1'b0);
        start_w();

        // abort on the tlast beat of a 64-byte frame
        send_beats(7, 7);
        drv(1'b1, bd(7, 7), 8'hFF, 1'b1, 1'b1);
        cyc("abort", ERR_W, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        drv(1'b1, bd(1, 0), 8'hFF, 1'b0, 1'b0);
        cyc("abort_term", TERM0_W, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_w("abort_ifg");
        start_w();

        // reset in the middle of DATA, then a fresh padded frame
        send_beats(1, 2);
        tx_rst = 1'b1;
        drv(1'b1, bd(1, 2), 8'hFF, 1'b0, 1'b0);
        idle_w("reset_mid_frame");
        tx_rst = 1'b0;
        drv(1'b1, bd(2, 0), 8'hFF, 1'b0, 1'b0);
        start_w();
        pad_13(2);
        cyc("post_rst_pad_term", 64'h070707FD00000000, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_w("tail_a");
        idle_w("tail_b");
        idle_w("tail_c");

        @(posedge tx_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words never compared, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
